flash_rd_arb: RTL and testbench
===============================

FLASH_RD_ARB -- requirements
Module: flash_rd_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4, number of cycles flash_oe_ is held low before data capture (legal range 1..15).
REQ-002 SHALL have parameter RST_CYCLES, default 13, number of cycles for the flash_reset_ low pulse and for the post-reset recovery (legal range 1..255).
REQ-003 SHALL have ports: clk25 in 1 system clock; rst_ in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid in 1, req0_addr in 21, req0_ready out 1, rsp0_valid out 1, rsp0_data out 16 (requester 0).
REQ-005 SHALL have ports: req1_valid in 1, req1_addr in 21, req1_ready out 1, rsp1_valid out 1, rsp1_data out 16 (requester 1).
REQ-006 SHALL have ports: flash_a out 21, flash_dq in 16 (read-only), flash_ce_ out 1, flash_oe_ out 1, flash_we_ out 1, flash_reset_ out 1, busy out 1.

Function
REQ-007 SHALL implement states RST_LO, RST_WAIT, IDLE, SETUP, ACCESS, DONE.
REQ-008 RST_LO: flash_reset_=0 for RST_CYCLES cycles, then RST_WAIT.
REQ-009 RST_WAIT: flash_reset_=1 for RST_CYCLES cycles, then IDLE; no request accepted in RST_LO/RST_WAIT.
REQ-010 IDLE: reqN_ready=1 only for the granted port with reqN_valid=1; the other ready=0; the handshake is reqN_valid&reqN_ready on a clk25 edge.
REQ-011 On handshake: latch the address into flash_a and latch the port id; next state SETUP.
REQ-012 SETUP (1 cycle): flash_ce_=0, flash_oe_=1; next state ACCESS.
REQ-013 ACCESS (WAIT_CYCLES cycles): flash_ce_=0, flash_oe_=0; on the last ACCESS edge, flash_dq is registered into the port's rsp data; next state DONE.
REQ-014 DONE (1 cycle): flash_ce_=1, flash_oe_=1, rspN_valid=1 for the latched port only; next state IDLE.
REQ-015 Latency: rspN_valid SHALL be high in the cycle starting WAIT_CYCLES+2 edges after the accepting edge; throughput SHALL be one read per WAIT_CYCLES+3 cycles.
REQ-016 rspN_data SHALL hold its value until the next response to that port.
REQ-017 flash_we_ SHALL be constant 1.
REQ-018 flash_a SHALL hold the last accepted address between accesses.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 A deassertion of reqN_valid without a handshake SHALL be permitted; nothing is issued.
REQ-021 A requester SHALL receive no response without a prior handshake, and exactly one response per handshake.

Reset
REQ-022 While rst_=0: state RST_LO with counter 0, flash_reset_=0, flash_ce_=1, flash_oe_=1, flash_we_=1, flash_a=0, both ready=0, both rsp_valid=0, both rsp_data=0, busy=1, last-served pointer=1.
REQ-023 Asserting rst_ mid-access SHALL abort the access immediately; no response is issued, and the full reset sequence is rerun.

Configuration
REQ-024 Macro FLASH_RD_ARB_RR_EN SHALL select the arbitration policy.
REQ-025 With FLASH_RD_ARB_RR_EN defined: round-robin; when both ports are valid in IDLE, grant the port not served last; a single valid port is always granted; the pointer updates on the handshake only.
REQ-026 Without FLASH_RD_ARB_RR_EN: fixed priority; port 0 wins whenever req0_valid=1; no pointer register exists.

Structure
REQ-027 A shared package flash_pkg SHALL hold: the state enum type, FLASH_AW=21, FLASH_DW=16, and the default WAIT_CYCLES/RST_CYCLES constants.
REQ-028 The grant logic SHALL be one sub-module, flash_rr_arb (2 valids in, grant one-hot out, handshake strobe in, macro-controlled policy); everything else stays in flash_rd_arb.

Verification
REQ-029 Reset release -> flash_reset_ low exactly 13 cycles, high 13 cycles, then req0_ready rises with req0_valid=1; busy=1 throughout.
REQ-030 Single read port 0, addr 0x1ABCD, flash model drives 0x5A3C -> flash_a=0x1ABCD; ce_ low 5 cycles; oe_ low 4 cycles; rsp0_valid pulse at edge 6 after handshake; rsp0_data=0x5A3C; rsp1_valid stays 0.
REQ-031 Both ports held valid for 4 reads, RR_EN defined -> grants 0,1,0,1 (pointer reset = 1); each response is routed to its own port with the correct data.
REQ-032 Same stimulus, RR_EN undefined -> four consecutive grants to port 0; port 1 is never ready.
REQ-033 rst_ asserted during ACCESS -> ce_/oe_ go to 1 and flash_reset_ to 0 without a clock edge; no rsp_valid occurs; the reset sequence repeats.
REQ-034 WAIT_CYCLES=1 and back-to-back requests on port 1 -> one response every 4 cycles; data changes between accesses are captured correctly.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read arbiter.
package flash_pkg;

    localparam int unsigned FLASH_AW = 21;
    localparam int unsigned FLASH_DW = 16;

    localparam int unsigned FLASH_WAIT_CYCLES = 4;
    localparam int unsigned FLASH_RST_CYCLES  = 13;

    typedef enum logic [2:0] {
        RST_LO,
        RST_WAIT,
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } flash_state_e;

endpackage

// File: rtl/flash_rr_arb.sv
// Two-port grant logic for the flash read path.
// FLASH_RD_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module flash_rr_arb (
    input  logic       clk25,
    input  logic       rst_,
    input  logic [1:0] valid,
    input  logic       hs,
    output logic [1:0] grant
);

`ifdef FLASH_RD_ARB_RR_EN
    logic last_q, last_d;

    // On contention favour the port that was not served last.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (hs) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk25, rst_, hs};

    always_comb begin
        grant = valid;
        if (valid[0]) begin
            grant[1] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/flash_rd_arb.sv
// Two-requester read arbiter for a parallel NOR flash, including power-up reset pulse.
// Arbitration policy is set by FLASH_RD_ARB_RR_EN (round-robin) or fixed priority by default.
module flash_rd_arb
    import flash_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = FLASH_WAIT_CYCLES,
    parameter int unsigned RST_CYCLES  = FLASH_RST_CYCLES
) (
    input  logic                clk25,
    input  logic                rst_,
    input  logic                req0_valid,
    input  logic [FLASH_AW-1:0] req0_addr,
    output logic                req0_ready,
    output logic                rsp0_valid,
    output logic [FLASH_DW-1:0] rsp0_data,
    input  logic                req1_valid,
    input  logic [FLASH_AW-1:0] req1_addr,
    output logic                req1_ready,
    output logic                rsp1_valid,
    output logic [FLASH_DW-1:0] rsp1_data,
    output logic [FLASH_AW-1:0] flash_a,
    input  logic [FLASH_DW-1:0] flash_dq,
    output logic                flash_ce_,
    output logic                flash_oe_,
    output logic                flash_we_,
    output logic                flash_reset_,
    output logic                busy
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0] ACC_LAST = 8'(WAIT_CYCLES - 1);

    flash_state_e        state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [FLASH_AW-1:0] flash_a_q, flash_a_d;
    logic                port_q, port_d;
    logic [FLASH_DW-1:0] rsp0_data_q, rsp0_data_d;
    logic [FLASH_DW-1:0] rsp1_data_q, rsp1_data_d;
    logic [1:0]          grant;
    logic                hs;

    flash_rr_arb u_arb (
        .clk25 (clk25),
        .rst_  (rst_),
        .valid ({req1_valid, req0_valid}),
        .hs    (hs),
        .grant (grant)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flash_a_d    = flash_a_q;
        port_d       = port_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        hs           = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        flash_ce_    = 1'b1;
        flash_oe_    = 1'b1;
        flash_reset_ = 1'b1;
        busy         = 1'b1;

        unique case (state_q)
            RST_LO: begin
                flash_reset_ = 1'b0;
                if (cnt_q == RST_LAST) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IDLE: begin
                busy       = 1'b0;
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (|grant) begin
                    hs        = 1'b1;
                    flash_a_d = grant[1] ? req1_addr : req0_addr;
                    port_d    = grant[1];
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                flash_ce_ = 1'b0;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                flash_ce_ = 1'b0;
                flash_oe_ = 1'b0;
                if (cnt_q == ACC_LAST) begin
                    if (port_q) begin
                        rsp1_data_d = flash_dq;
                    end else begin
                        rsp0_data_d = flash_dq;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                rsp0_valid = ~port_q;
                rsp1_valid = port_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = RST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            state_q     <= RST_LO;
            cnt_q       <= '0;
            flash_a_q   <= '0;
            port_q      <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flash_a_q   <= flash_a_d;
            port_q      <= port_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    assign flash_a   = flash_a_q;
    assign rsp0_data = rsp0_data_q;
    assign rsp1_data = rsp1_data_q;
    assign flash_we_ = 1'b1;

endmodule

// File: tb/tb_flash_rd_arb.sv
// Directed bench for flash_rd_arb; expected grant order follows FLASH_RD_ARB_RR_EN.
module tb_flash_rd_arb;

    logic        clk25;
    logic        rst_;
    logic        req0_valid, req1_valid;
    logic [20:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic [20:0] flash_a;
    logic [15:0] flash_dq;
    logic        flash_ce_, flash_oe_, flash_we_, flash_reset_, busy;

    logic        req0_valid_b, req1_valid_b;
    logic [20:0] req0_addr_b, req1_addr_b;
    logic        req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b;
    logic [15:0] rsp0_data_b, rsp1_data_b;
    logic [20:0] flash_a_b;
    logic [15:0] flash_dq_b;
    logic        flash_ce_b, flash_oe_b, flash_we_b, flash_reset_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] fmodel(input logic [20:0] a);
        if (a == 21'h1ABCD) return 16'h5A3C;
        return a[15:0] ^ 16'hC3A5 ^ {11'd0, a[20:16]};
    endfunction

    assign flash_dq   = fmodel(flash_a);
    assign flash_dq_b = fmodel(flash_a_b);

    flash_rd_arb u_dut (
        .clk25(clk25), .rst_(rst_),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .flash_a(flash_a), .flash_dq(flash_dq), .flash_ce_(flash_ce_), .flash_oe_(flash_oe_),
        .flash_we_(flash_we_), .flash_reset_(flash_reset_), .busy(busy)
    );

    flash_rd_arb #(.WAIT_CYCLES(1), .RST_CYCLES(2)) u_dut_b (
        .clk25(clk25), .rst_(rst_),
        .req0_valid(req0_valid_b), .req0_addr(req0_addr_b), .req0_ready(req0_ready_b),
        .rsp0_valid(rsp0_valid_b), .rsp0_data(rsp0_data_b),
        .req1_valid(req1_valid_b), .req1_addr(req1_addr_b), .req1_ready(req1_ready_b),
        .rsp1_valid(rsp1_valid_b), .rsp1_data(rsp1_data_b),
        .flash_a(flash_a_b), .flash_dq(flash_dq_b), .flash_ce_(flash_ce_b), .flash_oe_(flash_oe_b),
        .flash_we_(flash_we_b), .flash_reset_(flash_reset_b), .busy(busy_b)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk25);
        #1;
    endtask

    // Counts samples with flash_reset_ low, then high until busy drops.
    task automatic measure_rst(output int lo, output int hi, output logic busy_ok, output logic rsp_seen);
        lo = 0; hi = 0; busy_ok = 1'b1; rsp_seen = 1'b0;
        while (flash_reset_ == 1'b0 && lo < 300) begin
            lo++;
            if (!busy || req0_ready || req1_ready) busy_ok = 1'b0;
            if (rsp0_valid || rsp1_valid) rsp_seen = 1'b1;
            tick();
        end
        while (flash_reset_ == 1'b1 && busy && hi < 300) begin
            hi++;
            if (req0_ready || req1_ready) busy_ok = 1'b0;
            if (rsp0_valid || rsp1_valid) rsp_seen = 1'b1;
            tick();
        end
    endtask

    initial begin
        int lo, hi, n, ce_lo, oe_lo, rsp_at, rsp_cnt, k, r, last_t, t;
        logic busy_ok, rsp_seen, rsp1_seen, p1_ready_seen;
        logic [1:0]  g [4];
        logic [1:0]  exp_g [4];
        logic [20:0] addr_q [$];
        logic [20:0] a_exp;

        rst_ = 1'b0;
        req0_valid = 1'b1; req0_addr = 21'h1ABCD;
        req1_valid = 1'b0; req1_addr = '0;
        req0_valid_b = 1'b0; req0_addr_b = '0;
        req1_valid_b = 1'b0; req1_addr_b = 21'h00100;

        // Reset state
        tick(); tick();
        chk("rst_flash_reset", {31'd0, flash_reset_}, 32'd0);
        chk("rst_ce_oe_we", {29'd0, flash_ce_, flash_oe_, flash_we_}, 32'h7);
        chk("rst_flash_a", {11'd0, flash_a}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_rsp_data", {rsp0_data, rsp1_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Reset sequence
        rst_ = 1'b1;
        #1;
        measure_rst(lo, hi, busy_ok, rsp_seen);
        chk("seq_lo_cycles", lo, 32'd13);
        chk("seq_hi_cycles", hi, 32'd13);
        chk("seq_busy_no_ready", {31'd0, busy_ok}, 32'd1);
        chk("seq_ready_rises", {31'd0, req0_ready}, 32'd1);

        // Single read on port 0; handshake edge counted as edge 1
        n = 0; ce_lo = 0; oe_lo = 0; rsp_at = 0; rsp_cnt = 0; rsp1_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n++;
            if (c == 0) begin
                req0_valid = 1'b0;
                chk("rd_flash_a", {11'd0, flash_a}, 32'h1ABCD);
            end
            if (!flash_ce_) ce_lo++;
            if (!flash_oe_) oe_lo++;
            if (rsp0_valid) begin
                rsp_cnt++;
                rsp_at = n;
            end
            if (rsp1_valid) rsp1_seen = 1'b1;
        end
        chk("rd_ce_low", ce_lo, 32'd5);
        chk("rd_oe_low", oe_lo, 32'd4);
        chk("rd_rsp_edge", rsp_at, 32'd6);
        chk("rd_rsp_count", rsp_cnt, 32'd1);
        chk("rd_rsp1_quiet", {31'd0, rsp1_seen}, 32'd0);
        chk("rd_data_held", {16'd0, rsp0_data}, 32'h5A3C);
        chk("rd_addr_held", {11'd0, flash_a}, 32'h1ABCD);
        chk("rd_we_high", {31'd0, flash_we_}, 32'd1);

        // Reset asserted during ACCESS
        req0_addr = 21'h00042;
        req0_valid = 1'b1;
        #1;
        chk("ab_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("ab_in_access", {30'd0, flash_ce_, flash_oe_}, 32'd0);
        #5;
        rst_ = 1'b0;
        #1;
        chk("ab_async_pins", {29'd0, flash_ce_, flash_oe_, flash_reset_}, 32'h6);
        chk("ab_busy", {31'd0, busy}, 32'd1);
        rsp_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rsp0_valid || rsp1_valid) rsp_seen = 1'b1;
        end
        rst_ = 1'b1;
        #1;
        begin
            logic rs2;
            measure_rst(lo, hi, busy_ok, rs2);
            rsp_seen = rsp_seen | rs2;
        end
        chk("ab_lo_cycles", lo, 32'd13);
        chk("ab_hi_cycles", hi, 32'd13);
        chk("ab_no_rsp", {31'd0, rsp_seen}, 32'd0);
        chk("ab_data_cleared", {16'd0, rsp0_data}, 32'd0);

        // Both ports held valid for four reads
`ifdef FLASH_RD_ARB_RR_EN
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0; exp_g[3] = 2'd1;
`else
        exp_g[0] = 2'd0; exp_g[1] = 2'd0; exp_g[2] = 2'd0; exp_g[3] = 2'd0;
`endif
        req0_addr = 21'h00123;
        req1_addr = 21'h1F000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        k = 0; r = 0; p1_ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) g[i] = 2'd3;
        for (int c = 0; c < 80 && (k < 4 || r < 4); c++) begin
            if (req1_ready) p1_ready_seen = 1'b1;
            if (k < 4 && (req0_ready || req1_ready)) begin
                g[k] = req1_ready ? 2'd1 : 2'd0;
                k++;
            end
            if (rsp0_valid || rsp1_valid) begin
                if (r < 4) begin
                    chk($sformatf("rr_rsp_port%0d", r), {30'd0, rsp1_valid, rsp0_valid},
                        exp_g[r] == 2'd1 ? 32'd2 : 32'd1);
                    chk($sformatf("rr_rsp_data%0d", r), {16'd0, rsp1_valid ? rsp1_data : rsp0_data},
                        {16'd0, fmodel(exp_g[r] == 2'd1 ? 21'h1F000 : 21'h00123)});
                end
                r++;
            end
            tick();
            if (k == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1;
            end
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), {30'd0, g[i]}, {30'd0, exp_g[i]});
        chk("rr_rsp_total", r, 32'd4);
`ifndef FLASH_RD_ARB_RR_EN
        chk("fp_port1_never_ready", {31'd0, p1_ready_seen}, 32'd0);
`endif

        // WAIT_CYCLES=1, back-to-back reads on port 1
        req1_valid_b = 1'b1;
        #1;
        k = 0; r = 0; last_t = 0; t = 0; rsp_seen = 1'b0;
        for (int c = 0; c < 60 && r < 4; c++) begin
            if (req1_ready_b) begin
                addr_q.push_back(req1_addr_b);
                k++;
            end
            if (rsp0_valid_b) rsp_seen = 1'b1;
            if (rsp1_valid_b) begin
                a_exp = (addr_q.size() > 0) ? addr_q.pop_front() : 21'h0;
                chk($sformatf("b2b_data%0d", r), {16'd0, rsp1_data_b}, {16'd0, fmodel(a_exp)});
                if (r > 0) chk($sformatf("b2b_gap%0d", r), t - last_t, 32'd4);
                last_t = t;
                r++;
                if (r == 4) req1_valid_b = 1'b0;
            end
            tick();
            t++;
            if (k > 0 && flash_ce_b == 1'b0 && req1_valid_b) req1_addr_b = req1_addr_b + 21'h01111;
        end
        chk("b2b_rsp_total", r, 32'd4);
        chk("b2b_port0_quiet", {31'd0, rsp_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
